// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode encoding, FSM states and the
// status-flag bundle carried with every registered result.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_INCR = 4'd3,
    OP_DECR = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_NOT  = 4'd7,
    OP_NAND = 4'd8,
    OP_NOR  = 4'd9,
    OP_XOR  = 4'd10,
    OP_XNOR = 4'd11,
    OP_ARSH = 4'd12,
    OP_ALSH = 4'd13,
    OP_LRSH = 4'd14,
    OP_LLSH = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
    logic err;
  } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Only instantiated by alu_seq_core when ALU_SEQ_MUL_EN is defined.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     operand_a,
  input  logic [WIDTH-1:0]     operand_b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int SHW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_p0;
  logic [WIDTH-1:0]   mplier_p0;
  logic [2*WIDTH-1:0] acc_p0;
  logic [SHW:0]       cnt_p0;
  logic [2*WIDTH-1:0] acc_nxt;

  // Product including the current iteration; valid as the final result when done
  assign acc_nxt = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);
  assign product = acc_nxt;
  assign done    = (cnt_p0 == (SHW+1)'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0 <= '0;
    end else if (start) begin
      cnt_p0 <= (SHW+1)'(WIDTH);
    end else if (cnt_p0 != '0) begin
      cnt_p0 <= cnt_p0 - 1'b1;
    end
  end

  // ---- stage p0: operand latch and accumulator ----
  always_ff @(posedge clk) begin
    if (start) begin
      mcand_p0  <= {{WIDTH{1'b0}}, operand_a};
      mplier_p0 <= operand_b;
      acc_p0    <= '0;
    end else if (cnt_p0 != '0) begin
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
      acc_p0    <= acc_nxt;
    end
  end

endmodule

// File: rtl/alu_seq_core.sv
// Handshaked sequential ALU with registered result and flags.
// Define ALU_SEQ_MUL_EN to build the iterative multiplier; otherwise MUL reports flag_err.
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             flag_err
);

  localparam int SHW = $clog2(WIDTH);

`ifdef ALU_SEQ_MUL_EN
  localparam logic MUL_ERR = 1'b0;
`else
  localparam logic MUL_ERR = 1'b1;
`endif

  state_e                    state_p0, state_nxt;
  opcode_e                   op;
  logic                      accept, is_mul;
  logic [WIDTH-1:0]          addend;
  logic [WIDTH:0]            sum, diff;
  logic signed [WIDTH-1:0]   opa_s;
  logic [SHW-1:0]            sh, sh_m1, sh_l;
  logic [WIDTH-1:0]          op_lo;
  flags_t                    op_fl;
  logic [WIDTH-1:0]          lo_p1, hi_p1;
  flags_t                    fl_p1;

  assign op       = opcode_e'(opcode);
  assign in_ready = (state_p0 == ST_IDLE) || (state_p0 == ST_DONE && out_ready);
  assign accept   = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
  logic                 mul_done;
  logic [2*WIDTH-1:0]   mul_prod;
  flags_t               mul_fl;

  assign is_mul = (op == OP_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && is_mul),
    .operand_a (operand1),
    .operand_b (operand2),
    .done      (mul_done),
    .product   (mul_prod)
  );

  always_comb begin
    mul_fl   = '0;
    mul_fl.z = (mul_prod == '0);
    mul_fl.n = mul_prod[2*WIDTH-1];
  end
`else
  assign is_mul = 1'b0;
`endif

  // Single-cycle operations
  always_comb begin
    addend = (op == OP_INCR || op == OP_DECR) ? {{(WIDTH-1){1'b0}}, 1'b1} : operand2;
    sum    = {1'b0, operand1} + {1'b0, addend};
    diff   = {1'b0, operand1} - {1'b0, addend};
    opa_s  = operand1;
    sh     = operand2[SHW-1:0];
    sh_m1  = sh - 1'b1;
    sh_l   = SHW'(0) - sh;
    op_lo  = '0;
    op_fl  = '0;
    case (op)
      OP_ADD, OP_INCR: begin
        op_lo   = sum[WIDTH-1:0];
        op_fl.c = sum[WIDTH];
        op_fl.v = (operand1[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_SUB, OP_DECR: begin
        op_lo   = diff[WIDTH-1:0];
        op_fl.c = diff[WIDTH];
        op_fl.v = (operand1[WIDTH-1] != addend[WIDTH-1]) && (diff[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_MUL:  op_fl.err = MUL_ERR;
      OP_AND:  op_lo = operand1 & operand2;
      OP_OR:   op_lo = operand1 | operand2;
      OP_NOT:  op_lo = ~operand1;
      OP_NAND: op_lo = ~(operand1 & operand2);
      OP_NOR:  op_lo = ~(operand1 | operand2);
      OP_XOR:  op_lo = operand1 ^ operand2;
      OP_XNOR: op_lo = ~(operand1 ^ operand2);
      OP_ARSH: begin
        op_lo   = opa_s >>> sh;
        op_fl.c = (sh != '0) && operand1[sh_m1];
      end
      OP_LRSH: begin
        op_lo   = operand1 >> sh;
        op_fl.c = (sh != '0) && operand1[sh_m1];
      end
      OP_ALSH, OP_LLSH: begin
        op_lo   = operand1 << sh;
        op_fl.c = (sh != '0) && operand1[sh_l];
      end
      default: op_lo = '0;
    endcase
    op_fl.z = (op_lo == '0);
    op_fl.n = op_lo[WIDTH-1];
  end

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      ST_IDLE: if (in_valid) state_nxt = is_mul ? ST_MUL : ST_DONE;
`ifdef ALU_SEQ_MUL_EN
      ST_MUL:  if (mul_done) state_nxt = ST_DONE;
`endif
      ST_DONE: if (out_ready) state_nxt = in_valid ? (is_mul ? ST_MUL : ST_DONE) : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ---- stage p1: registered result and flags ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= ST_IDLE;
      lo_p1    <= '0;
      hi_p1    <= '0;
      fl_p1    <= '0;
    end else begin
      state_p0 <= state_nxt;
      if (accept && !is_mul) begin
        lo_p1 <= op_lo;
        hi_p1 <= '0;
        fl_p1 <= op_fl;
      end
`ifdef ALU_SEQ_MUL_EN
      else if (mul_done) begin
        lo_p1 <= mul_prod[WIDTH-1:0];
        hi_p1 <= mul_prod[2*WIDTH-1:WIDTH];
        fl_p1 <= mul_fl;
      end
`endif
    end
  end

  assign out_valid = (state_p0 == ST_DONE);
  assign result_lo = lo_p1;
  assign result_hi = hi_p1;
  assign flag_c    = fl_p1.c;
  assign flag_z    = fl_p1.z;
  assign flag_n    = fl_p1.n;
  assign flag_v    = fl_p1.v;
  assign flag_err  = fl_p1.err;

endmodule

// File: tb/tb_alu_seq_core.sv
// Scoreboard bench for alu_seq_core at WIDTH=8; MUL expectations follow ALU_SEQ_MUL_EN.
module tb_alu_seq_core;

  localparam int W = 8;
  localparam logic [3:0] C_ADD = 4'd0, C_SUB = 4'd1, C_MUL = 4'd2, C_INCR = 4'd3,
                         C_DECR = 4'd4, C_AND = 4'd5, C_OR = 4'd6, C_NOT = 4'd7,
                         C_NAND = 4'd8, C_NOR = 4'd9, C_XOR = 4'd10, C_XNOR = 4'd11,
                         C_ARSH = 4'd12, C_ALSH = 4'd13, C_LRSH = 4'd14, C_LLSH = 4'd15;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic c, z, n, v, err;
  } res_t;

  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    res_t         e;
  } vec_t;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic [W-1:0] operand1 = '0, operand2 = '0;
  logic in_ready, out_valid, flag_c, flag_z, flag_n, flag_v, flag_err;
  logic [W-1:0] result_lo, result_hi;

  int checks = 0;
  int failures = 0;
  res_t exp_q[$];

  alu_seq_core #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .operand1(operand1), .operand2(operand2), .out_valid(out_valid), .out_ready(out_ready),
    .result_lo(result_lo), .result_hi(result_hi), .flag_c(flag_c), .flag_z(flag_z),
    .flag_n(flag_n), .flag_v(flag_v), .flag_err(flag_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic res_t mk(input logic [W-1:0] hi, lo, input logic c, z, n, v, err);
    res_t r;
    r.hi = hi; r.lo = lo; r.c = c; r.z = z; r.n = n; r.v = v; r.err = err;
    return r;
  endfunction

  function automatic vec_t mkv(input logic [3:0] op, input logic [W-1:0] a, b, input res_t e);
    vec_t t;
    t.op = op; t.a = a; t.b = b; t.e = e;
    return t;
  endfunction

  function automatic res_t act();
    return {result_hi, result_lo, flag_c, flag_z, flag_n, flag_v, flag_err};
  endfunction

  // Offer one op and return #1 after the accept edge.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, b, input res_t e);
    int n;
    opcode = op; operand1 = a; operand2 = b; in_valid = 1'b1;
    exp_q.push_back(e);
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (act() !== '0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got %h out_valid=%b required 0/0", act(), out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_arith();
    vec_t tbl[$];
    res_t got, e;
    int lat;
    tbl.push_back(mkv(C_ADD,  8'hFF, 8'h01, mk(8'h00, 8'h00, 1, 1, 0, 0, 0)));
    tbl.push_back(mkv(C_SUB,  8'h05, 8'h07, mk(8'h00, 8'hFE, 1, 0, 1, 0, 0)));
    tbl.push_back(mkv(C_ADD,  8'h7F, 8'h01, mk(8'h00, 8'h80, 0, 0, 1, 1, 0)));
    tbl.push_back(mkv(C_INCR, 8'h7F, 8'h55, mk(8'h00, 8'h80, 0, 0, 1, 1, 0)));
    tbl.push_back(mkv(C_DECR, 8'h00, 8'h55, mk(8'h00, 8'hFF, 1, 0, 1, 0, 0)));
    tbl.push_back(mkv(C_SUB,  8'h80, 8'h01, mk(8'h00, 8'h7F, 0, 0, 0, 1, 0)));
    foreach (tbl[i]) begin
      send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e);
      wait_out(lat);
      got = act();
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL arith[%0d]: got %h required %h", i, got, e);
      end
      checks++;
      if (lat != 1) begin
        failures++;
        $display("FAIL arith_latency[%0d]: got %0d required 1", i, lat);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_logic();
    vec_t tbl[$];
    res_t got, e;
    int lat;
    tbl.push_back(mkv(C_AND,  8'hF0, 8'h3C, mk(8'h00, 8'h30, 0, 0, 0, 0, 0)));
    tbl.push_back(mkv(C_OR,   8'hF0, 8'h0F, mk(8'h00, 8'hFF, 0, 0, 1, 0, 0)));
    tbl.push_back(mkv(C_NOT,  8'h0F, 8'hFF, mk(8'h00, 8'hF0, 0, 0, 1, 0, 0)));
    tbl.push_back(mkv(C_NAND, 8'hFF, 8'hFF, mk(8'h00, 8'h00, 0, 1, 0, 0, 0)));
    tbl.push_back(mkv(C_NOR,  8'h00, 8'h00, mk(8'h00, 8'hFF, 0, 0, 1, 0, 0)));
    tbl.push_back(mkv(C_XNOR, 8'hA5, 8'h5A, mk(8'h00, 8'h00, 0, 1, 0, 0, 0)));
    foreach (tbl[i]) begin
      send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e);
      wait_out(lat);
      got = act();
      e = exp_q.pop_front();
      checks++;
      if (got !== e || lat != 1) begin
        failures++;
        $display("FAIL logic[%0d]: got %h lat %0d required %h lat 1", i, got, lat, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_shifts();
    vec_t tbl[$];
    res_t got, e;
    int lat;
    tbl.push_back(mkv(C_ARSH, 8'h80, 8'h03, mk(8'h00, 8'hF0, 0, 0, 1, 0, 0)));
    tbl.push_back(mkv(C_LRSH, 8'h81, 8'hF9, mk(8'h00, 8'h40, 1, 0, 0, 0, 0)));
    tbl.push_back(mkv(C_LLSH, 8'h81, 8'h00, mk(8'h00, 8'h81, 0, 0, 1, 0, 0)));
    tbl.push_back(mkv(C_ALSH, 8'h81, 8'h01, mk(8'h00, 8'h02, 1, 0, 0, 0, 0)));
    tbl.push_back(mkv(C_LLSH, 8'h01, 8'h07, mk(8'h00, 8'h80, 0, 0, 1, 0, 0)));
    tbl.push_back(mkv(C_ARSH, 8'h44, 8'h03, mk(8'h00, 8'h08, 1, 0, 0, 0, 0)));
    foreach (tbl[i]) begin
      send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].e);
      wait_out(lat);
      got = act();
      e = exp_q.pop_front();
      checks++;
      if (got !== e || lat != 1) begin
        failures++;
        $display("FAIL shift[%0d]: got %h lat %0d required %h lat 1", i, got, lat, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mul();
    res_t got, e;
    int lat, elat;
    logic busy_bad;
    logic [W-1:0] a, b;
    for (int i = 0; i < 2; i++) begin
      a = (i == 0) ? 8'hFF : 8'h0D;
      b = (i == 0) ? 8'hFF : 8'h0B;
`ifdef ALU_SEQ_MUL_EN
      e = (i == 0) ? mk(8'hFE, 8'h01, 0, 0, 1, 0, 0) : mk(8'h00, 8'h8F, 0, 0, 0, 0, 0);
      elat = W + 1;
`else
      e = mk(8'h00, 8'h00, 0, 1, 0, 0, 1);
      elat = 1;
`endif
      send(C_MUL, a, b, e);
      operand1 = ~a;
      operand2 = 8'h00;
      opcode = C_ADD;
      lat = 1;
      busy_bad = 1'b0;
      while (out_valid !== 1'b1 && lat < 40) begin
        if (in_ready !== 1'b0) busy_bad = 1'b1;
        @(posedge clk); #1; lat++;
      end
      got = act();
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL mul[%0d]: got %h required %h", i, got, e);
      end
      checks++;
      if (lat != elat) begin
        failures++;
        $display("FAIL mul_latency[%0d]: got %0d required %0d", i, lat, elat);
      end
      checks++;
      if (busy_bad !== 1'b0) begin
        failures++;
        $display("FAIL mul_in_ready[%0d]: in_ready seen 1 while busy, required 0", i);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    vec_t tbl[$];
    res_t got, e;
    out_ready = 1'b0;
    send(C_XOR, 8'hF0, 8'h3C, mk(8'h00, 8'hCC, 0, 0, 1, 0, 0));
    e = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      got = act();
      checks++;
      if (got !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold[%0d]: got %h v=%b rdy=%b required %h v=1 rdy=0",
                 i, got, out_valid, in_ready, e);
      end
      @(posedge clk); #1;
    end
    tbl.push_back(mkv(C_OR,  8'h01, 8'h02, mk(8'h00, 8'h03, 0, 0, 0, 0, 0)));
    tbl.push_back(mkv(C_ADD, 8'h10, 8'h20, mk(8'h00, 8'h30, 0, 0, 0, 0, 0)));
    tbl.push_back(mkv(C_SUB, 8'h20, 8'h20, mk(8'h00, 8'h00, 0, 1, 0, 0, 0)));
    out_ready = 1'b1;
    in_valid = 1'b1;
    foreach (tbl[i]) begin
      opcode = tbl[i].op; operand1 = tbl[i].a; operand2 = tbl[i].b;
      exp_q.push_back(tbl[i].e);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready[%0d]: got %b required 1", i, in_ready);
      end
      @(posedge clk); #1;
      got = act();
      e = exp_q.pop_front();
      checks++;
      if (got !== e || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL b2b[%0d]: got %h v=%b required %h v=1", i, got, out_valid, e);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mul();
    res_t got, e;
    int lat;
    logic seen;
    out_ready = 1'b1;
    send(C_MUL, 8'h12, 8'h34, mk(8'h00, 8'h00, 0, 0, 0, 0, 0));
    exp_q.delete();
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_state: v=%b rdy=%b required v=0 rdy=1", out_valid, in_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL abort_discard: out_valid seen 1 after reset, required 0");
    end
    send(C_AND, 8'hF0, 8'h3C, mk(8'h00, 8'h30, 0, 0, 0, 0, 0));
    wait_out(lat);
    got = act();
    e = exp_q.pop_front();
    checks++;
    if (got !== e || lat != 1) begin
      failures++;
      $display("FAIL after_abort: got %h lat %0d required %h lat 1", got, lat, e);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_shifts();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
